// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX line between NUM_REQ byte producers,
// with CTS gating at frame start. Define UART_TX_PARITY_EN for 8E1 framing (default 8N1).
module uart_tx_scheduler #(
  parameter int NUM_REQ  = 2,
  parameter int BAUD_DIV = 260
) (
  input  logic                 clk_30mhz,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 uart_cts,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [2:0]         bit_idx, bit_nxt;
  logic [7:0]         byte_q, dsel;
  logic [IW-1:0]      rr_ptr, gsel, ptr_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic [1:0]         cts_sync;
  logic               found, grant, cnt_last;
  int unsigned        idx;

  // First valid requester at or after the rotation pointer, wrapping.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[IW'(idx)]) begin
        found = 1'b1;
        gsel  = IW'(idx);
      end
    end
  end

  always_comb begin
    dsel    = '0;
    ack_nxt = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gsel == IW'(k)) begin
        dsel       = req_data[8*k +: 8];
        ack_nxt[k] = grant;
      end
    end
  end

  assign ptr_nxt  = (gsel == IW'(NUM_REQ - 1)) ? '0 : gsel + IW'(1);
  assign grant    = (state == IDLE) && found && !cts_sync[1];
  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_last ? '0 : cnt + CW'(1);
    bit_nxt   = bit_idx;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (grant) state_nxt = START;
      end
      START: begin
        if (cnt_last) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (cnt_last) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end
      end
      PARITY: if (cnt_last) state_nxt = STOP;
      STOP:   if (cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_30mhz) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_q   <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      req_ack  <= '0;
      cts_sync <= '1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      req_ack  <= ack_nxt;
      cts_sync <= {cts_sync[0], uart_cts};
      if (grant) begin
        byte_q   <= dsel;
        rr_ptr   <= ptr_nxt;
        grant_id <= 3'(gsel);
      end
    end
  end

  always_comb begin
    case (state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = byte_q[bit_idx];
      PARITY:  uart_tx = ^byte_q;
      default: uart_tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized self-checking bench for uart_tx_scheduler; expected line waveform and
// grant order come from a frame/rotation model, not from the design's state machine.
module tb_uart_tx_scheduler;

  localparam int NR = 2;
  localparam int BD = 260;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * BD;

  localparam int ACT_NONE  = 0;
  localparam int ACT_DROP  = 1;
  localparam int ACT_CTS   = 2;
  localparam int ACT_RAND  = 3;
  localparam int ACT_RESET = 4;

  logic          clk_30mhz = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] req_ack;
  logic          uart_cts = 1'b1;
  logic          uart_tx;
  logic          busy;
  logic [2:0]    grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int mdl_ptr = 0;

  uart_tx_scheduler #(.NUM_REQ(NR), .BAUD_DIV(BD)) dut (
    .clk_30mhz (clk_30mhz),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .uart_cts  (uart_cts),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #17 clk_30mhz = ~clk_30mhz;

  function automatic int model_grant(input logic [NR-1:0] v, input int p);
    logic [NR-1:0] t;
    for (int k = 0; k < NR; k++) begin
      t = v >> ((p + k) % NR);
      if (t[0]) return (p + k) % NR;
    end
    return 0;
  endfunction

  // Line bits in transmission order, index 0 = start bit.
  function automatic logic [NB-1:0] model_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  function automatic logic [7:0] byte_of(input int i);
    logic [8*NR-1:0] t;
    t = req_data >> (8 * i);
    return t[7:0];
  endfunction

  task automatic check_frame(input int eg, input logic [7:0] eb, input int max_wait,
                             input int act_cyc, input int act);
    logic [NB-1:0] sh;
    logic [NR-1:0] eack;
    logic bad, got_tx, got_busy, extra_ack;
    int w;
    sh   = model_bits(eb);
    eack = NR'(1) << eg;
    w = 0;
    while (uart_tx !== 1'b0 && w <= max_wait) begin
      @(negedge clk_30mhz);
      w++;
    end
    n_cmp++;
    if (uart_tx !== 1'b0) begin
      n_bad++;
      $display("FAIL start_wait: no start bit after %0d cycles, required within %0d", w, max_wait);
      return;
    end
    n_cmp++;
    if (req_ack !== eack) begin
      n_bad++;
      $display("FAIL ack_at_start: req_ack=%b required %b", req_ack, eack);
    end
    n_cmp++;
    if (grant_id !== 3'(eg)) begin
      n_bad++;
      $display("FAIL grant_id: got %0d required %0d", grant_id, eg);
    end
    mdl_ptr = (eg + 1) % NR;
    bad = 1'b0; got_tx = 1'b0; got_busy = 1'b0; extra_ack = 1'b0;
    for (int c = 0; c < FL; c++) begin
      if (c > 0 && c % BD == 0) sh = sh >> 1;
      if ((uart_tx !== sh[0] || busy !== 1'b1) && !bad) begin
        bad = 1'b1; got_tx = uart_tx; got_busy = busy;
      end
      if (c > 0 && req_ack !== '0) extra_ack = 1'b1;
      if (c % BD == BD - 1) begin
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL frame_bit%0d: tx=%b busy=%b, required tx=%b busy=1",
                   c / BD, got_tx, got_busy, sh[0]);
        end
        bad = 1'b0;
      end
      if (c == act_cyc) begin
        case (act)
          ACT_DROP: req_valid = '0;
          ACT_CTS:  uart_cts = 1'b1;
          ACT_RAND: begin
            req_data  = 16'($urandom);
            req_valid = 2'($urandom_range(1, 3));
          end
          ACT_RESET: begin
            reset = 1'b1;
            @(negedge clk_30mhz);
            n_cmp++;
            if (uart_tx !== 1'b1 || busy !== 1'b0 || grant_id !== 3'd0 || req_ack !== '0) begin
              n_bad++;
              $display("FAIL reset_midframe: tx=%b busy=%b grant=%0d ack=%b, required 1 0 0 00",
                       uart_tx, busy, grant_id, req_ack);
            end
            reset = 1'b0;
            mdl_ptr = 0;
            return;
          end
          default: ;
        endcase
      end
      @(negedge clk_30mhz);
    end
    n_cmp++;
    if (extra_ack) begin
      n_bad++;
      $display("FAIL ack_pulse: req_ack high beyond first cycle, required one-cycle pulse");
    end
    n_cmp++;
    if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_end: busy=%b tx=%b at cycle %0d, required busy=0 tx=1", busy, uart_tx, FL);
    end
  endtask

  task automatic idle_hold(input int n, input string name);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_30mhz);
      if (uart_tx !== 1'b1 || req_ack !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: line left idle, required tx=1 ack=00 busy=0 throughout", name);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_30mhz);
    reset = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_reset();
    uart_cts = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk_30mhz);
    n_cmp++;
    if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b required 1", uart_tx); end
    n_cmp++;
    if (req_ack !== '0) begin n_bad++; $display("FAIL reset_ack: got %b required 00", req_ack); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++;
    if (grant_id !== 3'd0) begin n_bad++; $display("FAIL reset_grant: got %0d required 0", grant_id); end
    reset = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic test_single();
    req_data  = 16'h0042;
    req_valid = 2'b01;
    check_frame(model_grant(req_valid, mdl_ptr), 8'h42, 6, 1, ACT_DROP);
    idle_hold(20, "single_no_repeat");
`ifdef UART_TX_PARITY_EN
    req_data  = 16'h0007;
    req_valid = 2'b01;
    check_frame(model_grant(req_valid, mdl_ptr), 8'h07, 4, 1, ACT_DROP);
    idle_hold(5, "parity_no_repeat");
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_data  = 16'h3CA5;
    req_valid = 2'b11;
    check_frame(model_grant(req_valid, mdl_ptr), 8'hA5, 6, ACT_NONE, ACT_NONE);
    check_frame(model_grant(req_valid, mdl_ptr), 8'h3C, 1, ACT_NONE, ACT_NONE);
    check_frame(model_grant(req_valid, mdl_ptr), 8'hA5, 1, 1, ACT_DROP);
    idle_hold(10, "b2b_release");
  endtask

  task automatic test_cts_block();
    uart_cts = 1'b1;
    repeat (3) @(negedge clk_30mhz);
    req_data  = 16'h0055;
    req_valid = 2'b01;
    idle_hold(5000, "cts_blocked");
    uart_cts = 1'b0;
    check_frame(model_grant(req_valid, mdl_ptr), 8'h55, 4, 1, ACT_DROP);
  endtask

  task automatic test_cts_midframe();
    req_data  = 16'h0096;
    req_valid = 2'b01;
    check_frame(model_grant(req_valid, mdl_ptr), 8'h96, 4, 1000, ACT_CTS);
    idle_hold(1000, "cts_midframe_wait");
    uart_cts = 1'b0;
    check_frame(model_grant(req_valid, mdl_ptr), 8'h96, 4, 1, ACT_DROP);
  endtask

  task automatic test_reset_midframe();
    req_data  = 16'hC318;
    req_valid = 2'b11;
    check_frame(model_grant(req_valid, mdl_ptr), byte_of(model_grant(req_valid, mdl_ptr)),
                4, 1300, ACT_RESET);
    check_frame(model_grant(req_valid, mdl_ptr), 8'h18, 8, 1, ACT_DROP);
  endtask

  task automatic test_random();
    int g;
    req_data  = 16'($urandom);
    req_valid = 2'($urandom_range(1, 3));
    for (int i = 0; i < 8; i++) begin
      g = model_grant(req_valid, mdl_ptr);
      check_frame(g, byte_of(g), 4, int'($urandom_range(1, FL - 2)), ACT_RAND);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cts_block();
    test_cts_midframe();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
